// File: rtl/uart_shell_pkg.sv
// Shared constants, state encodings and ASCII/hex helpers for the UART command shell.
package uart_shell_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_R  = 8'h72;
  localparam logic [7:0] ASCII_D  = 8'h64;
  localparam logic [7:0] ASCII_W  = 8'h77;
  localparam logic [7:0] ASCII_Q  = 8'h3F;
  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_K  = 8'h4B;

  typedef enum logic [2:0] {S_IDLE, S_STORE, S_PARSE, S_EXEC, S_REPLY, S_DONE} state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {REP_RD, REP_WR, REP_BAD} rep_t;

  // Bit 4 flags a legal hex digit; bits 3:0 carry its value.
  function automatic logic [4:0] hex_to_nib(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) return {1'b1, c[3:0] + 4'd9};
    return 5'd0;
  endfunction

  function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_shell_rx.sv
// 8N1 receiver: double-flopped input, mid-bit sampling, one-cycle rx_vld per byte.
// A start bit found high again at its midpoint is treated as a glitch and dropped.
module uart_rx
  import uart_shell_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_vld,
  output logic [7:0] rx_dat
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  rx_state_t     state, state_n;
  logic          rx_meta, rx_sync, vld_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;

  assign rx_dat = shift;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    bit_n   = bit_idx;
    shift_n = shift;
    vld_n   = 1'b0;
    case (state)
      R_IDLE: begin
        cnt_n = '0;
        if (!rx_sync) state_n = R_START;
      end
      R_START: if (cnt == HALF) begin
        cnt_n   = '0;
        bit_n   = '0;
        state_n = rx_sync ? R_IDLE : R_DATA;
      end
      R_DATA: if (cnt == LAST) begin
        cnt_n   = '0;
        shift_n = {rx_sync, shift[7:1]};
        bit_n   = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_n = R_STOP;
      end
      R_STOP: if (cnt == LAST) begin
        cnt_n   = '0;
        vld_n   = 1'b1;
        state_n = R_IDLE;
      end
      default: state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      state   <= R_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      rx_vld  <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      rx_vld  <= vld_n;
    end
  end
endmodule

// File: rtl/uart_shell.sv
// UART command shell: echoes a line, then runs "rd AAAA" / "wr AAAA DD" on a byte RAM.
// Replies wait on the transmitter busy flag; a pending echo always goes out before reply bytes.
module uart_shell
  import uart_shell_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int RAM_DEPTH    = 256,
  parameter int CMD_LEN      = 10
) (
  input  logic CLK,
  input  logic RST,
  input  logic UART_RX,
  output logic UART_TX
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(CMD_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  state_t        state, state_n;
  rep_t          rep_kind;
  logic          rx_vld, ovf, echo_vld, ram_we, is_rd, is_wr, addr_ok, rep_last;
  logic [7:0]    rx_dat, rx_byte, echo_dat, ram_q, wr_data, rep_byte;
  logic [7:0]    cmd_buf [CMD_LEN];
  logic [7:0]    ram [RAM_DEPTH];
  logic [IW-1:0] idx;
  logic [1:0]    step;
  logic [4:0]    h3, h4, h5, h6, h8, h9;
  logic [15:0]   addr16;
  logic [AW-1:0] ram_addr;
  logic [9:0]    tx_frame;
  logic [3:0]    tx_bits;
  logic [CW-1:0] tx_cnt;
  logic          tx_busy, tx_free, tx_go, fsm_req, fsm_take;
  logic [7:0]    tx_byte, fsm_byte;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(CLK), .rst(RST), .rx(UART_RX), .rx_vld(rx_vld), .rx_dat(rx_dat)
  );

  assign h3 = hex_to_nib(cmd_buf[3]);
  assign h4 = hex_to_nib(cmd_buf[4]);
  assign h5 = hex_to_nib(cmd_buf[5]);
  assign h6 = hex_to_nib(cmd_buf[6]);
  assign h8 = hex_to_nib(cmd_buf[8]);
  assign h9 = hex_to_nib(cmd_buf[9]);
  assign addr_ok  = h3[4] & h4[4] & h5[4] & h6[4];
  assign addr16   = {h3[3:0], h4[3:0], h5[3:0], h6[3:0]};
  assign ram_addr = AW'(addr16 % 16'(RAM_DEPTH));
  assign wr_data  = {h8[3:0], h9[3:0]};
  assign is_rd = !ovf && idx == IW'(7) && addr_ok && cmd_buf[0] == ASCII_R
                 && cmd_buf[1] == ASCII_D && cmd_buf[2] == ASCII_SP;
  assign is_wr = !ovf && idx == IW'(10) && addr_ok && h8[4] && h9[4] && cmd_buf[0] == ASCII_W
                 && cmd_buf[1] == ASCII_R && cmd_buf[2] == ASCII_SP && cmd_buf[7] == ASCII_SP;

  always_ff @(posedge CLK) begin
    if (ram_we) ram[ram_addr] <= wr_data;
    ram_q <= ram[ram_addr];
  end

  // Accepting on the final stop-bit cycle keeps consecutive frames gap-free.
  assign tx_free  = !tx_busy || (tx_bits == 4'd9 && tx_cnt == LAST);
  assign fsm_take = fsm_req && !echo_vld && tx_free;
  assign tx_go    = tx_free && (echo_vld || fsm_req);
  assign tx_byte  = echo_vld ? echo_dat : fsm_byte;
  assign UART_TX  = tx_frame[0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_frame <= '1;
      tx_bits  <= '0;
      tx_cnt   <= '0;
      tx_busy  <= 1'b0;
    end else if (tx_go) begin
      tx_frame <= {1'b1, tx_byte, 1'b0};
      tx_bits  <= '0;
      tx_cnt   <= '0;
      tx_busy  <= 1'b1;
    end else if (tx_busy) begin
      if (tx_cnt == LAST) begin
        tx_cnt   <= '0;
        tx_frame <= {1'b1, tx_frame[9:1]};
        tx_bits  <= tx_bits + 4'd1;
        if (tx_bits == 4'd9) tx_busy <= 1'b0;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    rep_byte = ASCII_LF;
    rep_last = 1'b0;
    case (rep_kind)
      REP_RD: case (step)
        2'd0:    rep_byte = nib_to_hex(ram_q[7:4]);
        2'd1:    rep_byte = nib_to_hex(ram_q[3:0]);
        2'd2:    rep_byte = ASCII_CR;
        default: rep_last = 1'b1;
      endcase
      REP_WR: case (step)
        2'd0:    rep_byte = ASCII_O;
        2'd1:    rep_byte = ASCII_K;
        2'd2:    rep_byte = ASCII_CR;
        default: rep_last = 1'b1;
      endcase
      default: case (step)
        2'd0:    rep_byte = ASCII_Q;
        2'd1:    rep_byte = ASCII_CR;
        default: rep_last = 1'b1;
      endcase
    endcase
  end

  always_comb begin
    state_n  = state;
    fsm_req  = 1'b0;
    fsm_byte = ASCII_CR;
    ram_we   = 1'b0;
    case (state)
      S_IDLE:  if (rx_vld) state_n = (rx_dat == ASCII_CR) ? S_PARSE : S_STORE;
      S_STORE: state_n = S_IDLE;
      S_PARSE: begin
        fsm_req  = 1'b1;
        fsm_byte = step[0] ? ASCII_LF : ASCII_CR;
        if (fsm_take && step[0]) state_n = S_EXEC;
      end
      S_EXEC: begin
        ram_we  = is_wr;
        state_n = (idx == '0 && !ovf) ? S_DONE : S_REPLY;
      end
      S_REPLY: begin
        fsm_req  = 1'b1;
        fsm_byte = rep_byte;
        if (fsm_take && rep_last) state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      idx      <= '0;
      ovf      <= 1'b0;
      rx_byte  <= '0;
      echo_vld <= 1'b0;
      echo_dat <= '0;
      step     <= '0;
      rep_kind <= REP_BAD;
      for (int i = 0; i < CMD_LEN; i++) cmd_buf[i] <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && rx_vld) rx_byte <= rx_dat;
      if (tx_go && echo_vld) echo_vld <= 1'b0;
      // A newer echo overwrites the holding register even if the old one is still queued.
      if (state == S_STORE) begin
        echo_vld <= 1'b1;
        echo_dat <= rx_byte;
        if (idx < IW'(CMD_LEN)) begin
          cmd_buf[idx] <= rx_byte;
          idx          <= idx + 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end
      if (fsm_take) step <= step + 2'd1;
      if (state == S_EXEC) begin
        step     <= '0;
        rep_kind <= is_rd ? REP_RD : (is_wr ? REP_WR : REP_BAD);
      end
      if (state == S_DONE) begin
        idx  <= '0;
        ovf  <= 1'b0;
        step <= '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_shell.sv
// Directed bench for uart_shell: drives command lines over UART_RX and decodes UART_TX.
module tb_uart_shell;
  localparam int CPB = 8;
  localparam int BIT = CPB * 10;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       UART_RX = 1'b1;
  logic       UART_TX;
  logic [7:0] q [$];
  logic [7:0] mon_b;
  string      CRLF;
  string      s;
  int         n_cmp = 0;
  int         n_bad = 0;

  uart_shell #(.CLKS_PER_BIT(CPB), .RAM_DEPTH(256), .CMD_LEN(10)) dut (
    .CLK(CLK), .RST(RST), .UART_RX(UART_RX), .UART_TX(UART_TX)
  );

  always #5 CLK = ~CLK;

  // Serial decoder for UART_TX; samples each bit 3 time units past its midpoint.
  initial begin
    forever begin
      @(negedge UART_TX);
      #(BIT / 2 + 3);
      if (UART_TX === 1'b0) begin
        for (int k = 0; k < 8; k++) begin
          #(BIT);
          mon_b[k] = UART_TX;
        end
        #(BIT);
        q.push_back(mon_b);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    UART_RX = 1'b0;
    #(BIT);
    for (int k = 0; k < 8; k++) begin
      UART_RX = b[k];
      #(BIT);
    end
    UART_RX = 1'b1;
    #(BIT);
  endtask

  task automatic wait_bytes(input int n);
    for (int i = 0; i < 400 * CPB && q.size() < n; i++) @(negedge CLK);
  endtask

  // Sends line + CR and expects: echo of the line, CR LF, then the reply bytes.
  task automatic check_line(input string line, input string reply);
    string       exp_s;
    logic [31:0] obs;
    exp_s = {line, CRLF, reply};
    q.delete();
    for (int i = 0; i < line.len(); i++) send_byte(line[i]);
    send_byte(8'h0D);
    wait_bytes(exp_s.len());
    repeat (12 * CPB) @(negedge CLK);
    check({"count '", line, "'"}, q.size(), exp_s.len());
    for (int i = 0; i < exp_s.len(); i++) begin
      obs = (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF;
      check($sformatf("'%s' byte %0d", line, i), obs, 32'(exp_s[i]));
    end
  endtask

  initial begin
    logic [31:0] obs;
    CRLF    = "..";
    CRLF[0] = 8'h0D;
    CRLF[1] = 8'h0A;

    repeat (5) @(negedge CLK);
    check("tx during reset", UART_TX, 1);
    RST = 1'b0;
    repeat (20 * CPB) @(negedge CLK);
    check("tx idle after reset", UART_TX, 1);
    check("no output after reset", q.size(), 0);

    check_line("rd 0000", {"00", CRLF});
    check_line("wr 0012 37", {"OK", CRLF});
    check_line("rd 0012", {"37", CRLF});
    obs = (q.size() >= 3) ? 32'(q[q.size() - 3]) : 32'hFFFF_FFFF;
    check("last data byte", obs, 32'h37);
    check_line("rd 0112", {"37", CRLF});
    check_line("xy 1234", {"?", CRLF});
    check_line("rd 00G0", {"?", CRLF});
    check_line("rd 012", {"?", CRLF});
    check_line("wr 0012 3", {"?", CRLF});
    check_line("rd 0012", {"37", CRLF});
    check_line("wr 00aB c4", {"OK", CRLF});
    check_line("rd 00AB", {"C4", CRLF});
    check_line("", "");
    check_line("abcdefghijkl", {"?", CRLF});
    check_line("rd 0000", {"00", CRLF});

    // Reset during the start bit of the first reply byte.
    q.delete();
    s = "rd 0012";
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    send_byte(8'h0D);
    wait_bytes(9);
    for (int i = 0; i < 40 * CPB && UART_TX === 1'b1; i++) @(negedge CLK);
    check("reply started", UART_TX, 0);
    #20;
    RST = 1'b1;
    #2;
    check("tx high on reset", UART_TX, 1);
    repeat (4) @(negedge CLK);
    check("tx high in reset", UART_TX, 1);
    RST = 1'b0;
    repeat (14 * CPB) @(negedge CLK);
    check("tx idle after mid-reply reset", UART_TX, 1);
    check_line("rd 0000", {"00", CRLF});
    check_line("rd 0012", {"37", CRLF});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
